// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer, its program ROM and the
// multicycle core.
//   MemAddr : ROM address, driven by the sequencer
//   MemData : ROM read data, valid the cycle after MemAddr
//   DIN     : word offered to the core (instruction or immediate)
//   Run     : high while DIN carries a word for the core
//   Done    : core completion strobe
// Handshake: a word is offered while Run=1 and DIN is stable. The offer
// completes on the first rising edge in the WAIT state at which Done=1.
// Done seen at any other time is ignored.
interface instr_sequencer_if #(
   parameter int AW = 5
);
   logic [AW-1:0] MemAddr;
   logic [15:0]   MemData;
   logic [15:0]   DIN;
   logic          Run;
   logic          Done;

   modport master (output MemAddr, output DIN, output Run,
                   input  MemData, input  Done);
   modport slave  (input  MemAddr, input  DIN, input  Run,
                   output MemData, output Done);
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/issue stage in front of a 16-bit multicycle core.
// Reads words from a synchronous ROM and offers each instruction on DIN with
// Run high. For mvi (opcode 001), the immediate follows on DIN one cycle
// later. The stage stops on a halt opcode (111), or when the core gives no
// Done for MAX_WAIT cycles.
// Ports:
//   Clock, Resetn : clock (rising edge), asynchronous active-low reset
//   Go            : start/restart pulse, honoured only in IDLE and HALT
//   bus           : ROM and core bus (MemAddr, MemData, DIN, Run, Done)
//   PC            : current program counter
//   Halted        : high in HALT
//   Timeout       : sticky, set when the core failed to answer
//   InstrCount    : instructions retired, wraps
//   fsm_state     : current state encoding, for observation
module instr_sequencer #(
   parameter int AW         = 5,
   parameter int START_ADDR = 0,
   parameter int MAX_WAIT   = 8
) (
   input  logic                Clock,
   input  logic                Resetn,
   input  logic                Go,
   instr_sequencer_if.master   bus,
   output logic [AW-1:0]       PC,
   output logic                Halted,
   output logic                Timeout,
   output logic [15:0]         InstrCount,
   output logic [2:0]          fsm_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      ISSUE  = 3'd3,
      WAIT   = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [2:0]    OP_MVI   = 3'b001;
   localparam logic [2:0]    OP_HALT  = 3'b111;
   localparam int            CW       = $clog2(MAX_WAIT + 1);
   localparam logic [AW-1:0] START_PC = AW'(START_ADDR);
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WAIT - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [15:0]   din_q, din_d;
   logic          run_q, run_d;
   logic          halted_q, halted_d;
   logic          timeout_q, timeout_d;
   logic [15:0]   count_q, count_d;
   logic [CW-1:0] wait_q, wait_d;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= IDLE;
         pc_q      <= START_PC;
         din_q     <= 16'h0000;
         run_q     <= 1'b0;
         halted_q  <= 1'b0;
         timeout_q <= 1'b0;
         count_q   <= 16'h0000;
         wait_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         din_q     <= din_d;
         run_q     <= run_d;
         halted_q  <= halted_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
         wait_q    <= wait_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      din_d     = din_q;
      run_d     = run_q;
      halted_d  = halted_q;
      timeout_d = timeout_q;
      count_d   = count_q;
      wait_d    = wait_q;
      case (state_q)
         IDLE: begin
            if (Go) state_d = FETCH;
         end
         FETCH: begin
            state_d = DECODE;
         end
         DECODE: begin
            // MemData now holds ROM[PC]. A halt leaves PC pointing at itself.
            if (bus.MemData[15:13] == OP_HALT) begin
               halted_d = 1'b1;
               state_d  = HALT;
            end else begin
               din_d   = bus.MemData;
               run_d   = 1'b1;
               pc_d    = pc_q + AW'(1);
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // The core latches IR from DIN this cycle. MemData already holds
            // the word after the instruction, which is the mvi immediate.
            if (din_q[15:13] == OP_MVI) begin
               din_d = bus.MemData;
               pc_d  = pc_q + AW'(1);
            end
            state_d = WAIT;
         end
         WAIT: begin
            // Done takes priority over a timeout in the same cycle.
            if (bus.Done) begin
               run_d   = 1'b0;
               count_d = count_q + 16'd1;
               wait_d  = '0;
               state_d = FETCH;
            end else begin
               wait_d = wait_q + CW'(1);
               if (wait_q == LAST_CNT) begin
                  timeout_d = 1'b1;
                  halted_d  = 1'b1;
                  run_d     = 1'b0;
                  state_d   = HALT;
               end
            end
         end
         HALT: begin
            if (Go) begin
               pc_d      = START_PC;
               halted_d  = 1'b0;
               timeout_d = 1'b0;
               wait_d    = '0;
               state_d   = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // In DECODE the ROM is asked for the following word early, so it is
   // already on MemData in ISSUE in case it is an immediate.
   always_comb begin
      bus.MemAddr = pc_q;
      if (state_q == DECODE) bus.MemAddr = pc_q + AW'(1);
   end

   assign bus.DIN    = din_q;
   assign bus.Run    = run_q;
   assign PC         = pc_q;
   assign Halted     = halted_q;
   assign Timeout    = timeout_q;
   assign InstrCount = count_q;
   assign fsm_state  = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer. Two instances share the clock, reset,
// Go, Done and the ROM contents: dut_a starts at address 0, and dut_b starts
// at address 31 to exercise PC wrap-around.
module tb_instr_sequencer;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_ISSUE  = 3'd3;
   localparam logic [2:0] S_WAIT   = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   logic        Clock;
   logic        Resetn;
   logic        go;
   logic        done;
   logic [15:0] rom [0:31];

   logic [4:0]  pc_a, pc_b;
   logic        halted_a, halted_b, timeout_a, timeout_b;
   logic [15:0] count_a, count_b;
   logic [2:0]  st_a, st_b;

   int checks = 0;
   int errors = 0;

   instr_sequencer_if #(.AW(5)) ifa ();
   instr_sequencer_if #(.AW(5)) ifb ();

   instr_sequencer #(.AW(5), .START_ADDR(0), .MAX_WAIT(8)) dut_a (
      .Clock(Clock), .Resetn(Resetn), .Go(go), .bus(ifa.master),
      .PC(pc_a), .Halted(halted_a), .Timeout(timeout_a),
      .InstrCount(count_a), .fsm_state(st_a)
   );

   instr_sequencer #(.AW(5), .START_ADDR(31), .MAX_WAIT(8)) dut_b (
      .Clock(Clock), .Resetn(Resetn), .Go(go), .bus(ifb.master),
      .PC(pc_b), .Halted(halted_b), .Timeout(timeout_b),
      .InstrCount(count_b), .fsm_state(st_b)
   );

   assign ifa.Done = done;
   assign ifb.Done = done;

   // Synchronous ROMs: data appears the cycle after the address.
   always @(posedge Clock) ifa.MemData <= rom[ifa.MemAddr];
   always @(posedge Clock) ifb.MemData <= rom[ifb.MemAddr];

   // Clock and reset block
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic cycle();
      @(posedge Clock);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
   endtask

   task automatic do_reset();
      go     = 1'b0;
      done   = 1'b0;
      Resetn = 1'b0;
      cycle();
      cycle();
      Resetn = 1'b1;
      cycle();
   endtask

   task automatic test_reset();
      clear_rom();
      do_reset();
      checks++;
      if (st_a !== S_IDLE || pc_a !== 5'd0 || ifa.DIN !== 16'h0000 || ifa.Run !== 1'b0) begin
         errors++;
         $display("FAIL reset_a: state=%0d pc=%0d din=%h run=%b, required state=0 pc=0 din=0000 run=0",
                  st_a, pc_a, ifa.DIN, ifa.Run);
      end
      checks++;
      if (halted_a !== 1'b0 || timeout_a !== 1'b0 || count_a !== 16'd0) begin
         errors++;
         $display("FAIL reset_flags: halted=%b timeout=%b count=%0d, required 0 0 0",
                  halted_a, timeout_a, count_a);
      end
      checks++;
      if (pc_b !== 5'd31 || ifb.MemAddr !== 5'd31) begin
         errors++;
         $display("FAIL reset_b_pc: pc=%0d addr=%0d, required 31 31", pc_b, ifb.MemAddr);
      end
   endtask

   task automatic test_mvi();
      clear_rom();
      rom[0] = 16'h2400;
      rom[1] = 16'h0005;
      rom[2] = 16'hE000;
      do_reset();
      go = 1'b1;
      cycle();                 // FETCH
      go = 1'b0;
      cycle();                 // DECODE
      cycle();                 // ISSUE
      checks++;
      if (st_a !== S_ISSUE || ifa.DIN !== 16'h2400 || ifa.Run !== 1'b1 || pc_a !== 5'd1) begin
         errors++;
         $display("FAIL mvi_issue: state=%0d din=%h run=%b pc=%0d, required 3 2400 1 1",
                  st_a, ifa.DIN, ifa.Run, pc_a);
      end
      cycle();                 // first WAIT cycle
      checks++;
      if (st_a !== S_WAIT || ifa.DIN !== 16'h0005 || ifa.Run !== 1'b1 || pc_a !== 5'd2) begin
         errors++;
         $display("FAIL mvi_imm: state=%0d din=%h run=%b pc=%0d, required 4 0005 1 2",
                  st_a, ifa.DIN, ifa.Run, pc_a);
      end
      done = 1'b1;
      cycle();                 // back to FETCH
      done = 1'b0;
      checks++;
      if (st_a !== S_FETCH || ifa.Run !== 1'b0 || count_a !== 16'd1) begin
         errors++;
         $display("FAIL mvi_retire: state=%0d run=%b count=%0d, required 1 0 1",
                  st_a, ifa.Run, count_a);
      end
      cycle();                 // DECODE of halt
      cycle();                 // HALT
      checks++;
      if (st_a !== S_HALT || pc_a !== 5'd2 || halted_a !== 1'b1 || count_a !== 16'd1 ||
          ifa.Run !== 1'b0 || ifa.DIN !== 16'h0005) begin
         errors++;
         $display("FAIL mvi_halt: state=%0d pc=%0d halted=%b count=%0d run=%b din=%h, required 5 2 1 1 0 0005",
                  st_a, pc_a, halted_a, count_a, ifa.Run, ifa.DIN);
      end
   endtask

   task automatic test_late_done();
      int run_hi;
      clear_rom();
      rom[0] = 16'h0080;
      rom[1] = 16'hE000;
      do_reset();
      go = 1'b1;
      cycle();                 // edge 1: FETCH
      go = 1'b0;
      run_hi = 0;
      // Done is held in the third WAIT cycle, so edge 7 samples it.
      for (int e = 2; e <= 9; e++) begin
         done = (e == 7);
         cycle();
         if (ifa.Run === 1'b1) run_hi++;
      end
      done = 1'b0;
      checks++;
      if (run_hi != 4) begin
         errors++;
         $display("FAIL run_length: run high %0d cycles, required 4", run_hi);
      end
      checks++;
      if (st_a !== S_HALT || count_a !== 16'd1 || pc_a !== 5'd1 || halted_a !== 1'b1) begin
         errors++;
         $display("FAIL late_done_end: state=%0d count=%0d pc=%0d halted=%b, required 5 1 1 1",
                  st_a, count_a, pc_a, halted_a);
      end
   endtask

   task automatic test_timeout();
      clear_rom();
      rom[0] = 16'h0080;
      rom[1] = 16'hE000;
      do_reset();
      go = 1'b1;
      cycle();                 // edge 1
      go = 1'b0;
      for (int e = 2; e <= 11; e++) cycle();
      // Seven WAIT cycles have passed and the eighth is now in progress.
      checks++;
      if (st_a !== S_WAIT || timeout_a !== 1'b0 || ifa.Run !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: state=%0d timeout=%b run=%b, required 4 0 1",
                  st_a, timeout_a, ifa.Run);
      end
      cycle();                 // edge 12
      checks++;
      if (st_a !== S_HALT || timeout_a !== 1'b1 || halted_a !== 1'b1 ||
          ifa.Run !== 1'b0 || count_a !== 16'd0) begin
         errors++;
         $display("FAIL timeout_hit: state=%0d timeout=%b halted=%b run=%b count=%0d, required 5 1 1 0 0",
                  st_a, timeout_a, halted_a, ifa.Run, count_a);
      end
      go = 1'b1;
      cycle();
      go = 1'b0;
      checks++;
      if (st_a !== S_FETCH || timeout_a !== 1'b0 || halted_a !== 1'b0 ||
          pc_a !== 5'd0 || ifa.MemAddr !== 5'd0) begin
         errors++;
         $display("FAIL timeout_restart: state=%0d timeout=%b halted=%b pc=%0d addr=%0d, required 1 0 0 0 0",
                  st_a, timeout_a, halted_a, pc_a, ifa.MemAddr);
      end
      cycle();
      cycle();
      checks++;
      if (st_a !== S_ISSUE || ifa.DIN !== 16'h0080 || pc_a !== 5'd1) begin
         errors++;
         $display("FAIL timeout_refetch: state=%0d din=%h pc=%0d, required 3 0080 1",
                  st_a, ifa.DIN, pc_a);
      end
      // The wait counter must start from zero again: the eighth WAIT cycle is still WAIT.
      for (int i = 0; i < 8; i++) cycle();
      checks++;
      if (st_a !== S_WAIT || timeout_a !== 1'b0) begin
         errors++;
         $display("FAIL timeout_cnt_clear: state=%0d timeout=%b, required 4 0", st_a, timeout_a);
      end
   endtask

   task automatic test_wrap();
      clear_rom();
      rom[31] = 16'h2400;
      rom[0]  = 16'hABCD;
      rom[1]  = 16'hE000;
      do_reset();
      go = 1'b1;
      cycle();                 // FETCH at 31
      go = 1'b0;
      cycle();                 // DECODE
      checks++;
      if (ifb.MemAddr !== 5'd0) begin
         errors++;
         $display("FAIL wrap_addr: addr=%0d, required 0", ifb.MemAddr);
      end
      cycle();                 // ISSUE
      cycle();                 // WAIT
      checks++;
      if (st_b !== S_WAIT || ifb.DIN !== 16'hABCD) begin
         errors++;
         $display("FAIL wrap_imm: state=%0d din=%h, required 4 abcd", st_b, ifb.DIN);
      end
      done = 1'b1;
      cycle();
      done = 1'b0;
      checks++;
      if (pc_b !== 5'd1 || count_b !== 16'd1 || st_b !== S_FETCH) begin
         errors++;
         $display("FAIL wrap_pc: pc=%0d count=%0d state=%0d, required 1 1 1", pc_b, count_b, st_b);
      end
   endtask

   task automatic test_async_reset();
      clear_rom();
      rom[0] = 16'h2400;
      rom[1] = 16'h0005;
      rom[2] = 16'hE000;
      do_reset();
      go = 1'b1;
      cycle();
      go = 1'b0;
      cycle();
      cycle();
      cycle();                 // WAIT of the mvi, DIN=0005, PC=2
      #2;
      Resetn = 1'b0;
      #1;
      checks++;
      if (ifa.Run !== 1'b0 || ifa.DIN !== 16'h0000 || pc_a !== 5'd0 || st_a !== S_IDLE) begin
         errors++;
         $display("FAIL async_reset: run=%b din=%h pc=%0d state=%0d, required 0 0000 0 0",
                  ifa.Run, ifa.DIN, pc_a, st_a);
      end
      cycle();
      Resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         done = i[0];
         cycle();
      end
      done = 1'b0;
      checks++;
      if (st_a !== S_IDLE || ifa.Run !== 1'b0 || count_a !== 16'd0 || pc_a !== 5'd0) begin
         errors++;
         $display("FAIL post_reset_idle: state=%0d run=%b count=%0d pc=%0d, required 0 0 0 0",
                  st_a, ifa.Run, count_a, pc_a);
      end
   endtask

   task automatic test_stray_done();
      clear_rom();
      rom[0] = 16'h0080;
      rom[1] = 16'hE000;
      do_reset();
      done = 1'b1;
      cycle();                 // Done during IDLE
      done = 1'b0;
      checks++;
      if (st_a !== S_IDLE || count_a !== 16'd0) begin
         errors++;
         $display("FAIL done_idle: state=%0d count=%0d, required 0 0", st_a, count_a);
      end
      go = 1'b1;
      cycle();                 // edge 1: FETCH
      go = 1'b0;
      done = 1'b1;
      cycle();                 // edge 2: Done during FETCH
      done = 1'b0;
      cycle();                 // edge 3: ISSUE
      done = 1'b1;
      cycle();                 // edge 4: Done during ISSUE
      done = 1'b0;
      checks++;
      if (st_a !== S_WAIT || count_a !== 16'd0 || ifa.Run !== 1'b1) begin
         errors++;
         $display("FAIL done_early: state=%0d count=%0d run=%b, required 4 0 1",
                  st_a, count_a, ifa.Run);
      end
      for (int e = 5; e <= 11; e++) cycle();
      done = 1'b1;             // Done on the eighth WAIT cycle, as the timer expires
      cycle();                 // edge 12
      done = 1'b0;
      checks++;
      if (st_a !== S_FETCH || count_a !== 16'd1 || timeout_a !== 1'b0 ||
          halted_a !== 1'b0 || ifa.Run !== 1'b0) begin
         errors++;
         $display("FAIL done_coincident: state=%0d count=%0d timeout=%b halted=%b run=%b, required 1 1 0 0 0",
                  st_a, count_a, timeout_a, halted_a, ifa.Run);
      end
      cycle();
      cycle();
      checks++;
      if (st_a !== S_HALT || timeout_a !== 1'b0 || pc_a !== 5'd1) begin
         errors++;
         $display("FAIL coincident_halt: state=%0d timeout=%b pc=%0d, required 5 0 1",
                  st_a, timeout_a, pc_a);
      end
   endtask

   initial begin
      Resetn = 1'b0;
      go     = 1'b0;
      done   = 1'b0;
      test_reset();
      test_mvi();
      test_late_done();
      test_timeout();
      test_wrap();
      test_async_reset();
      test_stray_done();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
